// File: rtl/nios_system_input_ctrl.sv
// Avalon-MM input-port controller: per-bit synchronizer, debounce, edge capture
// with write-1-to-clear, and a masked level interrupt to the CPU.
module nios_system_input_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [1:0]       control_q;
    logic [1:0]       control_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    logic             wr_en_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] clr_s;
    logic             unused_s;

    assign wr_en_s  = chipselect & ~write_n;
    assign unused_s = ^writedata;

    // Per-bit debounce: count consecutive mismatches, commit after the full window
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edges are taken from the stable value as it commits, so capture lands on the same edge
    assign rise_s = stable_d & ~stable_q & {WIDTH{control_q[0]}};
    assign fall_s = ~stable_d & stable_q & {WIDTH{control_q[1]}};

    // Register writes; a same-cycle set beats a write-1-to-clear
    always_comb begin
        irqmask_d = irqmask_q;
        control_d = control_q;
        clr_s     = '0;
        if (wr_en_s) begin
            case (address)
                ADDR_IRQMASK: irqmask_d = writedata[WIDTH-1:0];
                ADDR_EDGECAP: clr_s     = writedata[WIDTH-1:0];
                ADDR_CONTROL: control_d = writedata[1:0];
                default:      irqmask_d = irqmask_q;
            endcase
        end else begin
            clr_s = '0;
        end
        edgecap_d = (edgecap_q & ~clr_s) | rise_s | fall_s;
    end

    // Read mux, zero-extended and registered every cycle
    always_comb begin
        case (address)
            ADDR_DATA:    readdata_d = 32'(stable_q);
            ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
            ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
            ADDR_CONTROL: readdata_d = 32'(control_q);
            default:      readdata_d = 32'd0;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            control_q  <= 2'd0;
            readdata_q <= 32'd0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            control_q  <= control_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_system_input_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a random
// phase, all checked each cycle against a window-based behavioural model.
module tb_nios_system_input_ctrl;

    localparam int W = 4;
    localparam int D = 16;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b1;
    logic [1:0]   address    = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n    = 1'b1;
    logic [31:0]  writedata  = 32'd0;
    logic [W-1:0] in_port    = '0;
    logic [31:0]  readdata;
    logic         irq;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    nios_system_input_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a bit's stable value flips when the last D synchronized
    // samples all disagree with it; the synchronizer is a two-sample delay.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_mask = '0, m_ec = '0;
    logic [1:0]   m_ctl = 2'd0;
    logic [31:0]  m_rd = 32'd0;
    logic [W-1:0] win[$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_ec = '0;
        m_ctl = 2'd0; m_rd = 32'd0;
        win.delete();
    endtask

    task automatic model_step();
        logic [W-1:0] nst, rise, fall, clr;
        bit wr, diff;
        wr = chipselect && !write_n;
        case (address)
            2'd0:    m_rd = 32'(m_stable);
            2'd1:    m_rd = 32'(m_mask);
            2'd2:    m_rd = 32'(m_ec);
            default: m_rd = 32'(m_ctl);
        endcase
        win.push_back(m_s2);
        if (win.size() > D) void'(win.pop_front());
        nst = m_stable;
        if (win.size() == D) begin
            for (int b = 0; b < W; b++) begin
                diff = 1'b1;
                foreach (win[i]) if (win[i][b] == m_stable[b]) diff = 1'b0;
                if (diff) nst[b] = ~m_stable[b];
            end
        end
        m_s2 = m_s1;
        m_s1 = in_port;
        rise = nst & ~m_stable & {W{m_ctl[0]}};
        fall = ~nst & m_stable & {W{m_ctl[1]}};
        clr  = (wr && address == 2'd2) ? writedata[W-1:0] : '0;
        m_ec = (m_ec & ~clr) | rise | fall;
        if (wr && address == 2'd1) m_mask = writedata[W-1:0];
        if (wr && address == 2'd3) m_ctl = writedata[1:0];
        m_stable = nst;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) model_reset();
        else model_step();
    end

    // Continuous comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("model_readdata", readdata, m_rd);
            check("model_irq", 32'(irq), 32'(|(m_ec & m_mask)));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        @(negedge clk);
        v = readdata;
    endtask

    task automatic do_reset(input logic [W-1:0] val);
        #3 reset_n = 1'b0;
        in_port = val;
        address = 2'd0;
        #1 check("in_reset_rd", readdata, 32'd0);
        check("in_reset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [31:0] v;

    initial begin
        #1 reset_n = 1'b0;
        in_port = 4'hF;
        #1 chk_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset values, then DATA picks up the held 4'hF
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            check("reset_reg", v, 32'd0);
        end
        check("reset_irq", 32'(irq), 32'd0);
        address = 2'd0;
        repeat (14) @(negedge clk);
        check("data_before_latency", readdata, 32'd0);
        @(negedge clk);
        check("data_after_latency", readdata, 32'h0000_000F);
        rd(2'd2, v);
        check("reset_edgecap", v, 32'd0);

        // Glitch of D-1 cycles is rejected
        do_reset('0);
        repeat (5) @(negedge clk);
        wr(2'd3, 32'd1);
        wr(2'd1, 32'd1);
        in_port[0] = 1'b1;
        repeat (D - 1) @(negedge clk);
        in_port[0] = 1'b0;
        repeat (25) @(negedge clk);
        rd(2'd0, v); check("glitch_data", v, 32'd0);
        rd(2'd2, v); check("glitch_edgecap", v, 32'd0);
        check("glitch_irq", 32'(irq), 32'd0);

        // Clean rising edge: irq rises right after edge k+17
        address = 2'd0;
        in_port[0] = 1'b1;
        repeat (17) @(negedge clk);
        check("rise_irq_pre", 32'(irq), 32'd0);
        @(negedge clk);
        check("rise_irq_post", 32'(irq), 32'd1);
        rd(2'd2, v); check("rise_edgecap", v, 32'd1);
        rd(2'd0, v); check("rise_data", v, 32'd1);

        // Clear and fall-detect on the same edge: set wins
        wr(2'd3, 32'd3);
        in_port[0] = 1'b0;
        repeat (17) @(negedge clk);
        wr(2'd2, 32'd1);
        rd(2'd2, v); check("w1c_set_wins", v, 32'd1);
        check("w1c_irq_held", 32'(irq), 32'd1);
        wr(2'd2, 32'd1);
        check("w1c_irq_fall", 32'(irq), 32'd0);
        rd(2'd2, v); check("w1c_cleared", v, 32'd0);

        // Falling edge captured while masked, then unmasked
        do_reset(4'b0100);
        repeat (25) @(negedge clk);
        wr(2'd3, 32'd2);
        wr(2'd1, 32'd0);
        in_port[2] = 1'b0;
        repeat (25) @(negedge clk);
        rd(2'd2, v); check("fall_edgecap", v, 32'd4);
        check("fall_masked_irq", 32'(irq), 32'd0);
        wr(2'd1, 32'd4);
        check("fall_unmasked_irq", 32'(irq), 32'd1);

        // Reset in the middle of a debounce count restarts the full latency
        do_reset('0);
        repeat (5) @(negedge clk);
        in_port[1] = 1'b1;
        repeat (12) @(negedge clk);
        #3 reset_n = 1'b0;
        #1 check("mid_reset_rd", readdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd0;
        repeat (18) @(negedge clk);
        check("mid_reset_data_pre", readdata, 32'd0);
        @(negedge clk);
        check("mid_reset_data_post", readdata, 32'd2);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 5) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 23) == 0)
                in_port[$urandom_range(0, W - 1)] ^= 1'b1;
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
